axi_stream_crc_checker: RTL and testbench

//  Receive-side counterpart of the sideband CRC generator: accepts an AXI-Stream frame whose
//  CRC-32 arrives as a sideband on the tlast beat, recomputes the CRC over the kept bytes,
//  and forwards the beats through a one-stage register slice. The tlast beat carries a

---
 rtl/axi_stream_crc_checker.sv | 275 +++++++++++++++++++++++++++
 tb/tb_axi_stream_crc_checker.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_crc_checker.sv
// -----------------------------------------------------------------------------
// axi_stream_crc_checker
//
// Receive-side CRC-32 checker for an AXI-Stream link. Each frame carries its
// expected CRC-32 as a sideband (i_s_crc) on the tlast beat. The block
// recomputes the CRC over the kept bytes of the frame and forwards every beat
// through a one-stage register slice. The forwarded tlast beat carries a
// pass/fail flag on o_m_tuser. Frames and failed frames are counted.
//
// CRC: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
// Bytes are consumed in order 0..KEEP_BYTES-1, LSB first within each byte.
//
// A frame fails when any of these hold:
//   - the final CRC differs from i_s_crc,
//   - a non-last beat has tkeep other than all-ones,
//   - the last beat has tkeep that is zero or not contiguous from bit 0.
//
// Ports
//   clk          clock
//   srst_n       reset, asynchronous assert, active-low
//   i_s_tdata    input data, byte k = tdata[8k+7:8k]
//   i_s_tkeep    input byte enables
//   i_s_tlast    input last beat of the frame
//   i_s_tvalid   input valid
//   o_s_tready   input ready (= ~o_m_tvalid | i_m_tready)
//   i_s_crc      expected CRC, sampled on an accepted tlast beat only
//   o_m_tdata    output data
//   o_m_tkeep    output byte enables
//   o_m_tlast    output last
//   o_m_tvalid   output valid
//   i_m_tready   output ready
//   o_m_tuser    error flag, valid on o_m_tlast beats, 0 otherwise
//   o_crc_err    one-cycle pulse after a failing tlast beat is accepted
//   i_clr_cnt    synchronous clear of both counters (wins over increment)
//   o_frame_cnt  accepted frames, saturating
//   o_err_cnt    failed frames, saturating
// -----------------------------------------------------------------------------
module axi_stream_crc_checker #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_BYTES = DATA_WIDTH / 8,
    parameter int CRC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  srst_n,
    input  logic [DATA_WIDTH-1:0] i_s_tdata,
    input  logic [KEEP_BYTES-1:0] i_s_tkeep,
    input  logic                  i_s_tlast,
    input  logic                  i_s_tvalid,
    output logic                  o_s_tready,
    input  logic [CRC_WIDTH-1:0]  i_s_crc,
    output logic [DATA_WIDTH-1:0] o_m_tdata,
    output logic [KEEP_BYTES-1:0] o_m_tkeep,
    output logic                  o_m_tlast,
    output logic                  o_m_tvalid,
    input  logic                  i_m_tready,
    output logic                  o_m_tuser,
    output logic                  o_crc_err,
    input  logic                  i_clr_cnt,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt,
    output logic [CNT_WIDTH-1:0]  o_err_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [CRC_WIDTH-1:0]  CRC_INIT  = {CRC_WIDTH{1'b1}};
    localparam logic [CRC_WIDTH-1:0]  CRC_XOR   = {CRC_WIDTH{1'b1}};
    localparam logic [CRC_WIDTH-1:0]  CRC_POLY  = 32'hEDB8_8320;
    localparam logic [KEEP_BYTES-1:0] KEEP_ALL  = {KEEP_BYTES{1'b1}};
    localparam logic [KEEP_BYTES-1:0] KEEP_ZERO = {KEEP_BYTES{1'b0}};
    localparam logic [KEEP_BYTES-1:0] KEEP_ONE  = {{(KEEP_BYTES-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // CRC helpers
    // ------------------------------------------------------------------

    // Advance a reflected CRC-32 by one byte, LSB first.
    function automatic logic [CRC_WIDTH-1:0] crc32_byte(
        input logic [CRC_WIDTH-1:0] crc,
        input logic [7:0]           data
    );
        logic [CRC_WIDTH-1:0] c;
        c = crc ^ {{(CRC_WIDTH-8){1'b0}}, data};
        for (int b = 0; b < 8; b++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Advance the CRC over every kept byte of one beat, byte 0 first.
    function automatic logic [CRC_WIDTH-1:0] crc32_beat(
        input logic [CRC_WIDTH-1:0]  crc,
        input logic [DATA_WIDTH-1:0] data,
        input logic [KEEP_BYTES-1:0] keep
    );
        logic [CRC_WIDTH-1:0] c;
        c = crc;
        for (int k = 0; k < KEEP_BYTES; k++) begin
            if (keep[k]) begin
                c = crc32_byte(c, data[8*k +: 8]);
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    // True when keep is non-zero and a run of ones starting at bit 0.
    // Adding one to such a mask carries through every set bit, so the AND is zero.
    function automatic logic keep_is_prefix(input logic [KEEP_BYTES-1:0] keep);
        return (keep != KEEP_ZERO) && ((keep & (keep + KEEP_ONE)) == KEEP_ZERO);
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CRC_WIDTH-1:0]   crc_acc_r;
    logic [CRC_WIDTH-1:0]   crc_base_s;
    logic [CRC_WIDTH-1:0]   crc_nxt_s;
    logic [CRC_WIDTH-1:0]   crc_final_s;
    logic                   sticky_r;
    logic                   sticky_base_s;
    logic                   keep_err_s;
    logic                   crc_mismatch_s;
    logic                   frame_err_s;
    logic                   accept_s;
    logic                   last_accept_s;

    // The slice can take a new beat when it is empty or draining this cycle.
    assign o_s_tready    = ~o_m_tvalid | i_m_tready;
    assign accept_s      = i_s_tvalid & o_s_tready;
    assign last_accept_s = accept_s & i_s_tlast;

    // Next-state logic: track whether we are between frames or inside one.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !i_s_tlast) begin
                    state_nxt_s = ST_BODY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BODY: begin
                if (accept_s && i_s_tlast) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BODY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // CRC and error evaluation for the beat currently on the input.
    // A frame's first beat always starts from the init value and a clean
    // sticky bit, whatever the accumulator happens to hold.
    always_comb begin
        crc_base_s     = CRC_INIT;
        sticky_base_s  = 1'b0;
        keep_err_s     = 1'b0;
        if (state_r == ST_BODY) begin
            crc_base_s    = crc_acc_r;
            sticky_base_s = sticky_r;
        end else begin
            crc_base_s    = CRC_INIT;
            sticky_base_s = 1'b0;
        end
        if (i_s_tlast) begin
            keep_err_s = ~keep_is_prefix(i_s_tkeep);
        end else begin
            keep_err_s = (i_s_tkeep != KEEP_ALL);
        end
        crc_nxt_s      = crc32_beat(crc_base_s, i_s_tdata, i_s_tkeep);
        crc_final_s    = crc_nxt_s ^ CRC_XOR;
        crc_mismatch_s = (crc_final_s != i_s_crc);
        frame_err_s    = sticky_base_s | keep_err_s | crc_mismatch_s;
    end

    // Frame state: FSM, running CRC and sticky tkeep error; hold under backpressure.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_r   <= ST_IDLE;
            crc_acc_r <= CRC_INIT;
            sticky_r  <= 1'b0;
        end else if (accept_s) begin
            state_r <= state_nxt_s;
            if (i_s_tlast) begin
                crc_acc_r <= CRC_INIT;
                sticky_r  <= 1'b0;
            end else begin
                crc_acc_r <= crc_nxt_s;
                sticky_r  <= sticky_base_s | keep_err_s;
            end
        end else begin
            state_r   <= state_r;
            crc_acc_r <= crc_acc_r;
            sticky_r  <= sticky_r;
        end
    end

    // Output register slice: load on accept, drop valid once drained.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            o_m_tdata  <= {DATA_WIDTH{1'b0}};
            o_m_tkeep  <= KEEP_ZERO;
            o_m_tlast  <= 1'b0;
            o_m_tuser  <= 1'b0;
            o_m_tvalid <= 1'b0;
        end else if (accept_s) begin
            o_m_tdata  <= i_s_tdata;
            o_m_tkeep  <= i_s_tkeep;
            o_m_tlast  <= i_s_tlast;
            o_m_tuser  <= i_s_tlast & frame_err_s;
            o_m_tvalid <= 1'b1;
        end else if (i_m_tready) begin
            o_m_tvalid <= 1'b0;
        end else begin
            o_m_tvalid <= o_m_tvalid;
        end
    end

    // Failure pulse, one cycle after the failing tlast beat is accepted.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            o_crc_err <= 1'b0;
        end else begin
            o_crc_err <= last_accept_s & frame_err_s;
        end
    end

    // Saturating frame and error counters; clear wins over increment.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            o_frame_cnt <= CNT_ZERO;
            o_err_cnt   <= CNT_ZERO;
        end else if (i_clr_cnt) begin
            o_frame_cnt <= CNT_ZERO;
            o_err_cnt   <= CNT_ZERO;
        end else if (last_accept_s) begin
            if (o_frame_cnt != CNT_MAX) begin
                o_frame_cnt <= o_frame_cnt + CNT_ONE;
            end else begin
                o_frame_cnt <= o_frame_cnt;
            end
            if (frame_err_s && (o_err_cnt != CNT_MAX)) begin
                o_err_cnt <= o_err_cnt + CNT_ONE;
            end else begin
                o_err_cnt <= o_err_cnt;
            end
        end else begin
            o_frame_cnt <= o_frame_cnt;
            o_err_cnt   <= o_err_cnt;
        end
    end

endmodule

// File: tb/tb_axi_stream_crc_checker.sv
// -----------------------------------------------------------------------------
// Testbench for axi_stream_crc_checker.
// A byte-level reference model (table-driven CRC-32 over a queue of kept
// bytes, a queue of expected output beats, saturating counters) tracks the
// stream; every cycle the DUT outputs are compared against it. Fixed vectors
// with known CRC values and hand-written sequences cover the corner cases,
// followed by randomized frames with random valid/ready behaviour.
// Counters are built 4 bits wide so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_axi_stream_crc_checker;

    localparam int DW = 512;
    localparam int KB = DW / 8;
    localparam int CW = 32;
    localparam int NW = 4;
    localparam int CMAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          srst_n;
    logic [DW-1:0] i_s_tdata;
    logic [KB-1:0] i_s_tkeep;
    logic          i_s_tlast;
    logic          i_s_tvalid;
    logic          o_s_tready;
    logic [CW-1:0] i_s_crc;
    logic [DW-1:0] o_m_tdata;
    logic [KB-1:0] o_m_tkeep;
    logic          o_m_tlast;
    logic          o_m_tvalid;
    logic          i_m_tready;
    logic          o_m_tuser;
    logic          o_crc_err;
    logic          i_clr_cnt;
    logic [NW-1:0] o_frame_cnt;
    logic [NW-1:0] o_err_cnt;

    always #5 clk = ~clk;

    axi_stream_crc_checker #(
        .DATA_WIDTH(DW), .KEEP_BYTES(KB), .CRC_WIDTH(CW), .CNT_WIDTH(NW)
    ) dut (
        .clk(clk), .srst_n(srst_n),
        .i_s_tdata(i_s_tdata), .i_s_tkeep(i_s_tkeep), .i_s_tlast(i_s_tlast),
        .i_s_tvalid(i_s_tvalid), .o_s_tready(o_s_tready), .i_s_crc(i_s_crc),
        .o_m_tdata(o_m_tdata), .o_m_tkeep(o_m_tkeep), .o_m_tlast(o_m_tlast),
        .o_m_tvalid(o_m_tvalid), .i_m_tready(i_m_tready), .o_m_tuser(o_m_tuser),
        .o_crc_err(o_crc_err), .i_clr_cnt(i_clr_cnt),
        .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
    );

    // ---------------- reference model state ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic [KB-1:0] keep;
        logic          last;
        logic          tuser;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  frame_bytes[$];
    bit          frame_bad;
    int          exp_frame_cnt;
    int          exp_err_cnt;
    logic [31:0] crc_tbl[256];

    int tests = 0;
    int fails = 0;
    int ready_mode;
    bit tog;
    bit last_acc;
    bit last_tuser;
    int n_drained;
    int n_ticks;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        return crc_tbl[c[7:0] ^ b] ^ (c >> 8);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        frame_bytes.delete();
        frame_bad     = 1'b0;
        exp_frame_cnt = 0;
        exp_err_cnt   = 0;
    endtask

    // Apply the rules to one accepted input beat.
    task automatic model_accept(output bit ferr);
        beat_t         b;
        int            n;
        logic [KB-1:0] m;
        logic [31:0]   c;
        ferr = 1'b0;
        for (int k = 0; k < KB; k++)
            if (i_s_tkeep[k]) frame_bytes.push_back(i_s_tdata[8*k +: 8]);
        if (!i_s_tlast) begin
            if (i_s_tkeep != {KB{1'b1}}) frame_bad = 1'b1;
        end else begin
            n = $countones(i_s_tkeep);
            m = {KB{1'b1}};
            if (n == 0) frame_bad = 1'b1;
            else begin
                m = m >> (KB - n);
                if (i_s_tkeep != m) frame_bad = 1'b1;
            end
        end
        b.data = i_s_tdata; b.keep = i_s_tkeep; b.last = i_s_tlast; b.tuser = 1'b0;
        if (i_s_tlast) begin
            c = 32'hFFFF_FFFF;
            foreach (frame_bytes[i]) c = crc_upd(c, frame_bytes[i]);
            c = ~c;
            ferr = frame_bad || (c != i_s_crc);
            b.tuser = ferr;
            frame_bytes.delete();
            frame_bad = 1'b0;
        end
        exp_q.push_back(b);
    endtask

    // One clock cycle: called just after a falling edge with inputs already set.
    task automatic tick();
        bit acc;
        bit ferr;
        bit pulse;
        case (ready_mode)
            1: i_m_tready = 1'($urandom_range(0, 1));
            2: begin i_m_tready = tog; tog = !tog; end
            default: i_m_tready = 1'b1;
        endcase
        #1;
        check("m_tvalid", DW'(o_m_tvalid), DW'(exp_q.size() != 0));
        check("s_tready", DW'(o_s_tready), DW'(!o_m_tvalid || i_m_tready));
        if (o_m_tvalid && exp_q.size() != 0) begin
            check("m_tdata", o_m_tdata, exp_q[0].data);
            check("m_tkeep", DW'(o_m_tkeep), DW'(exp_q[0].keep));
            check("m_tlast", DW'(o_m_tlast), DW'(exp_q[0].last));
            check("m_tuser", DW'(o_m_tuser), DW'(exp_q[0].tuser));
            if (i_m_tready) begin
                last_tuser = o_m_tuser;
                n_drained++;
                void'(exp_q.pop_front());
            end
        end
        acc   = i_s_tvalid && o_s_tready;
        ferr  = 1'b0;
        pulse = 1'b0;
        if (acc) begin
            model_accept(ferr);
            pulse = i_s_tlast && ferr;
        end
        if (i_clr_cnt) begin
            exp_frame_cnt = 0;
            exp_err_cnt   = 0;
        end else if (acc && i_s_tlast) begin
            if (exp_frame_cnt < CMAX) exp_frame_cnt++;
            if (ferr && exp_err_cnt < CMAX) exp_err_cnt++;
        end
        last_acc = acc;
        n_ticks++;
        @(negedge clk);
        check("crc_err", DW'(o_crc_err), DW'(pulse));
        check("frame_cnt", DW'(o_frame_cnt), DW'(exp_frame_cnt));
        check("err_cnt", DW'(o_err_cnt), DW'(exp_err_cnt));
    endtask

    task automatic rand_data(output logic [DW-1:0] d);
        for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom;
    endtask

    task automatic idle(input int n);
        logic [DW-1:0] d;
        i_s_tvalid = 1'b0;
        rand_data(d);
        i_s_tdata = d;
        i_s_tkeep = KB'($urandom);
        i_s_tlast = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KB-1:0] k,
                             input logic l, input logic [31:0] c);
        int budget;
        i_s_tdata = d; i_s_tkeep = k; i_s_tlast = l; i_s_crc = c; i_s_tvalid = 1'b1;
        budget = 50;
        last_acc = 1'b0;
        while (!last_acc && budget > 0) begin
            tick();
            budget--;
        end
        if (!last_acc) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
        i_s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        ready_mode = 0;
        i_s_tvalid = 1'b0;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
    endtask

    // Build and send an n-beat frame; last_n = kept bytes on the last beat.
    task automatic send_frame(input int n, input int gaps, input bit corrupt,
                              input bit mid_bad, input bit last_bad, input int last_n);
        logic [DW-1:0] d[4];
        logic [KB-1:0] k[4];
        logic [KB-1:0] m;
        logic [31:0]   c;
        for (int i = 0; i < n; i++) begin
            rand_data(d[i]);
            k[i] = {KB{1'b1}};
        end
        if (mid_bad && n >= 2) begin
            k[n-2] = '0;
            k[n-2][3:0] = 4'hF;
        end
        m = {KB{1'b1}};
        m = m >> (KB - last_n);
        if (last_bad) m[0] = 1'b0;
        k[n-1] = m;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < KB; b++)
                if (k[i][b]) c = crc_upd(c, d[i][8*b +: 8]);
        c = ~c;
        if (corrupt) c = c ^ (32'h1 << $urandom_range(0, 31));
        for (int i = 0; i < n; i++) begin
            if (gaps > 0) idle($urandom_range(0, gaps));
            send_beat(d[i], k[i], (i == n - 1), (i == n - 1) ? c : $urandom);
        end
    endtask

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic [31:0]  crc;
        logic         tuser;
        int           fcnt;
        int           ecnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] c;
        int          t0;
        int          d0;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tbl[i] = c;
        end

        vecs[0] = '{128'h393837363534333231, 16'h01FF, 32'hCBF4_3926, 1'b0, 1, 0};
        vecs[1] = '{128'h393837363534333231, 16'h01FF, 32'hCBF4_3927, 1'b1, 2, 1};
        vecs[2] = '{128'h61,                 16'h0001, 32'hE8B7_BE43, 1'b0, 3, 1};
        vecs[3] = '{128'h393837363534333231, 16'h01FD, 32'hCBF4_3926, 1'b1, 4, 2};
        vecs[4] = '{128'h393837363534333231, 16'h0000, 32'h0000_0000, 1'b1, 5, 3};
        vecs[5] = '{128'h393837363534333231, 16'h0001, 32'h83DC_EFB7, 1'b0, 6, 3};

        srst_n = 1'b0; i_s_tvalid = 1'b0; i_s_tdata = '0; i_s_tkeep = '0;
        i_s_tlast = 1'b0; i_s_crc = '0; i_m_tready = 1'b1; i_clr_cnt = 1'b0;
        ready_mode = 0; tog = 1'b1; n_drained = 0; n_ticks = 0; last_tuser = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tvalid", DW'(o_m_tvalid), DW'(0));
        check("rst_tdata", o_m_tdata, '0);
        check("rst_crc_err", DW'(o_crc_err), DW'(0));
        check("rst_frame_cnt", DW'(o_frame_cnt), DW'(0));
        check("rst_err_cnt", DW'(o_err_cnt), DW'(0));
        srst_n = 1'b1;
        @(negedge clk);

        // Fixed single-beat vectors with known CRC values.
        for (int v = 0; v < 6; v++) begin
            send_beat(DW'(vecs[v].data), KB'(vecs[v].keep), 1'b1, vecs[v].crc);
            idle(1);
            check("vec_tuser", DW'(last_tuser), DW'(vecs[v].tuser));
            check("vec_frame_cnt", DW'(o_frame_cnt), DW'(vecs[v].fcnt));
            check("vec_err_cnt", DW'(o_err_cnt), DW'(vecs[v].ecnt));
        end

        // Four-beat frame, last tkeep=0x3, output ready toggling 1010.
        ready_mode = 2; tog = 1'b1; d0 = n_drained;
        send_frame(4, 0, 1'b0, 1'b0, 1'b0, 2);
        drain();
        check("stall_beats", DW'(n_drained - d0), DW'(4));
        check("stall_tuser", DW'(last_tuser), DW'(0));

        // Back-to-back single-beat frames at full rate.
        ready_mode = 0; t0 = n_ticks;
        for (int i = 0; i < 8; i++) send_frame(1, 0, i[0], 1'b0, 1'b0, $urandom_range(1, KB));
        check("b2b_cycles", DW'(n_ticks - t0), DW'(8));
        drain();

        // Short middle beat poisons its frame; the following good frame passes.
        send_frame(3, 0, 1'b0, 1'b1, 1'b0, KB);
        drain();
        check("midkeep_tuser", DW'(last_tuser), DW'(1));
        send_frame(2, 0, 1'b0, 1'b0, 1'b0, 10);
        drain();
        check("after_bad_tuser", DW'(last_tuser), DW'(0));

        // Counter saturation at all-ones.
        i_clr_cnt = 1'b1; idle(1); i_clr_cnt = 1'b0;
        for (int i = 0; i < CMAX + 2; i++) send_frame(1, 0, 1'b1, 1'b0, 1'b0, 5);
        drain();
        check("sat_frame_cnt", DW'(o_frame_cnt), DW'(CMAX));
        check("sat_err_cnt", DW'(o_err_cnt), DW'(CMAX));

        // Reset in the middle of a frame, with a beat still in the slice.
        ready_mode = 0;
        send_beat({DW{1'b1}}, {KB{1'b1}}, 1'b0, 32'h0);
        send_beat({DW{1'b1}}, {KB{1'b1}}, 1'b0, 32'h0);
        srst_n = 1'b0;
        #1;
        check("midrst_tvalid", DW'(o_m_tvalid), DW'(0));
        check("midrst_tdata", o_m_tdata, '0);
        check("midrst_frame_cnt", DW'(o_frame_cnt), DW'(0));
        model_reset();
        @(negedge clk);
        srst_n = 1'b1;
        send_frame(3, 1, 1'b0, 1'b0, 1'b0, 33);
        drain();
        check("postrst_tuser", DW'(last_tuser), DW'(0));
        check("postrst_frame_cnt", DW'(o_frame_cnt), DW'(1));

        // Clear on the same cycle as a failing tlast accept.
        i_clr_cnt = 1'b1;
        send_frame(1, 0, 1'b1, 1'b0, 1'b0, 7);
        i_clr_cnt = 1'b0;
        check("clr_frame_cnt", DW'(o_frame_cnt), DW'(0));
        check("clr_err_cnt", DW'(o_err_cnt), DW'(0));
        drain();

        // Randomized frames with random valid gaps and output backpressure.
        for (int f = 0; f < 80; f++) begin
            ready_mode = 1;
            i_clr_cnt = ($urandom_range(0, 15) == 0);
            if (i_clr_cnt) begin idle(1); i_clr_cnt = 1'b0; end
            send_frame($urandom_range(1, 4), 2, ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                       $urandom_range(1, KB));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
